// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader
// Loads configuration beats into the fabric programming chain. Each accepted
// DATA_W-bit beat is shifted LSB-first into a CHAIN_LEN-bit chain through
// prog_clk/prog_en/prog_in, two clk cycles per bit. A CRC-8 (poly 0x07,
// init 0x00) tracks every bit shifted in.
//
// Optional feature macro: FPGA_CFG_READBACK_EN
//   defined   : after loading, the chain is circulated once through
//               prog_out -> prog_in, a second CRC is built from the bits seen
//               and compared with crc; a mismatch ends in ERROR.
//   undefined : loading goes straight to DONE, error is tied 0, prog_out
//               is ignored.
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   start     in   begin a load (honoured only in IDLE/DONE/ERROR)
//   in_data   in   configuration beat, LSB shifted first
//   in_valid  in   in_data valid
//   in_ready  out  loader can accept a beat
//   prog_clk  out  chain shift clock (registered)
//   prog_en   out  chain programming enable (registered)
//   prog_in   out  chain serial data in (registered)
//   prog_out  in   chain serial data out
//   busy      out  load or readback in progress
//   done      out  load (and readback) finished OK, held until start/rst
//   error     out  readback mismatch, held until start/rst
//   crc       out  CRC-8 of the bits loaded
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | waiting for start after reset
// LOAD      | in_ready high, waiting for a beat
// SHIFT     | shifting the bits of the current beat into the chain
// READBACK  | circulating the chain once, building the readback CRC
// DONE      | load completed, prog_en/prog_clk low
// ERROR     | readback CRC differed from crc
module fpga_cfg_loader #(
    parameter int CHAIN_LEN = 100,
    parameter int DATA_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              prog_clk,
    output logic              prog_en,
    output logic              prog_in,
    input  logic              prog_out,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        crc
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int K_W   = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
`ifdef FPGA_CFG_READBACK_EN
        S_READBACK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
    endfunction

    state_t            state_q, state_d;
    logic              phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // beat_q holds only the bits of the beat not yet presented on prog_in
    logic [DATA_W-1:0] beat_q, beat_d;
    logic [K_W-1:0]    left_q, left_d;
    logic [7:0]        crc_q, crc_d;
    logic              clk_q, clk_d;
    logic              en_q, en_d;
    logic              pin_q, pin_d;
    logic [31:0]       rem;
    logic [K_W-1:0]    k;
`ifdef FPGA_CFG_READBACK_EN
    logic [7:0]        crc_rb_q, crc_rb_d;
`else
    logic              unused_prog_out;
    assign unused_prog_out = prog_out;
`endif

    // bits this beat may still contribute; upper beat bits past the chain end are dropped
    assign rem = 32'(CHAIN_LEN) - 32'(cnt_q);
    assign k   = (rem >= 32'(DATA_W)) ? K_W'(DATA_W) : K_W'(rem);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= 1'b0;
            cnt_q    <= '0;
            beat_q   <= '0;
            left_q   <= '0;
            crc_q    <= 8'h00;
            clk_q    <= 1'b0;
            en_q     <= 1'b0;
            pin_q    <= 1'b0;
`ifdef FPGA_CFG_READBACK_EN
            crc_rb_q <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            left_q   <= left_d;
            crc_q    <= crc_d;
            clk_q    <= clk_d;
            en_q     <= en_d;
            pin_q    <= pin_d;
`ifdef FPGA_CFG_READBACK_EN
            crc_rb_q <= crc_rb_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        left_d   = left_q;
        crc_d    = crc_q;
        clk_d    = 1'b0;
        en_d     = en_q;
        pin_d    = pin_q;
`ifdef FPGA_CFG_READBACK_EN
        crc_rb_d = crc_rb_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    crc_d   = 8'h00;
                    en_d    = 1'b1;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    // first bit goes out with the accept edge so phase 0 follows at once
                    state_d = S_SHIFT;
                    phase_d = 1'b0;
                    beat_d  = in_data >> 1;
                    left_d  = k - K_W'(1);
                    pin_d   = in_data[0];
                    crc_d   = crc8_step(crc_q, in_data[0]);
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    clk_d   = 1'b1;
                end else if (left_q != '0) begin
                    phase_d = 1'b0;
                    beat_d  = beat_q >> 1;
                    left_d  = left_q - K_W'(1);
                    pin_d   = beat_q[0];
                    crc_d   = crc8_step(crc_q, beat_q[0]);
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (cnt_q != CNT_LAST) begin
                    state_d = S_LOAD;
                end else begin
`ifdef FPGA_CFG_READBACK_EN
                    // cnt_q now counts circulated bits
                    state_d  = S_READBACK;
                    phase_d  = 1'b0;
                    cnt_d    = CNT_W'(1);
                    pin_d    = prog_out;
                    crc_rb_d = crc8_step(8'h00, prog_out);
`else
                    state_d = S_DONE;
                    en_d    = 1'b0;
`endif
                end
            end
`ifdef FPGA_CFG_READBACK_EN
            S_READBACK: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    clk_d   = 1'b1;
                end else if (cnt_q != CNT_LAST) begin
                    phase_d  = 1'b0;
                    pin_d    = prog_out;
                    crc_rb_d = crc8_step(crc_rb_q, prog_out);
                    cnt_d    = cnt_q + CNT_W'(1);
                end else begin
                    state_d = (crc_rb_q == crc_q) ? S_DONE : S_ERROR;
                    en_d    = 1'b0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready = (state_q == S_LOAD);
    assign prog_clk = clk_q;
    assign prog_en  = en_q;
    assign prog_in  = pin_q;
    assign done     = (state_q == S_DONE);
    assign crc      = crc_q;
`ifdef FPGA_CFG_READBACK_EN
    assign busy  = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_READBACK);
    assign error = (state_q == S_ERROR);
`else
    assign busy  = (state_q == S_LOAD) || (state_q == S_SHIFT);
    assign error = 1'b0;
`endif

endmodule
